// File: rtl/dma_reg_axil_ctrl.sv
// AXI4-Lite slave front-end for the DMA register file.
// Accepts one read or write at a time, arbitrates conflicts round-robin,
// drives a combinational register-read mux and a single-cycle write strobe,
// and pops the frame-size FIFO once when its decode offset is read.
module dma_reg_axil_ctrl #(
  parameter int                            ADDR_DECODER_WIDTH   = 8,
  parameter logic [ADDR_DECODER_WIDTH-1:0] FRAME_SIZE_FIFO_ADDR = 8'h28
) (
  input  logic        aclk,
  input  logic        aresetn,
  // write address / data / response
  input  logic [31:0] s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic        s_bvalid,
  input  logic        s_bready,
  output logic [1:0]  s_bresp,
  // read address / data
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  // register file side
  output logic [31:0] mem_rd_addr,
  input  logic [31:0] mem_rd_data,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_strb,
  output logic        frame_size_fifo_ren
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_CAPT = 2'd1;
  localparam logic [1:0] RD_RESP = 2'd2;
  localparam logic [1:0] WR_RESP = 2'd3;

  logic [1:0] state;
  logic       prio_rd;   // 1: read wins the next conflict
  logic       rd_req;
  logic       wr_req;
  logic       rd_sel;
  logic       wr_sel;
  logic       idle;

  // Request qualification and round-robin pick; a lone requester always wins.
  always_comb begin
    idle   = (state == IDLE);
    rd_req = s_arvalid;
    wr_req = s_awvalid & s_wvalid;
    rd_sel = rd_req & (~wr_req | prio_rd);
    wr_sel = wr_req & ~rd_sel;
  end

  // Handshake and response outputs decode straight from the registered state,
  // so an asynchronous reset drops them in the same instant.
  always_comb begin
    s_arready           = idle & rd_sel;
    s_awready           = idle & wr_sel;
    s_wready            = idle & wr_sel;
    s_rvalid            = (state == RD_RESP);
    s_bvalid            = (state == WR_RESP);
    s_rresp             = 2'b00;
    s_bresp             = 2'b00;
    // RD_CAPT lasts one cycle per read, so this pops at most once per read
    // no matter how long the master stalls s_rready afterwards.
    frame_size_fifo_ren = (state == RD_CAPT) &&
                          (mem_rd_addr[ADDR_DECODER_WIDTH-1:0] == FRAME_SIZE_FIFO_ADDR);
  end

  // Transaction FSM, payload registers and arbitration priority flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      prio_rd     <= 1'b1;
      s_rdata     <= '0;
      mem_rd_addr <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_wr_strb <= '0;
    end else begin
      mem_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_sel) begin
            mem_rd_addr <= s_araddr;
            prio_rd     <= 1'b0;
            state       <= RD_CAPT;
          end else if (wr_sel) begin
            mem_wr_addr <= s_awaddr;
            mem_wr_data <= s_wdata;
            mem_wr_strb <= s_wstrb;
            mem_wr_en   <= 1'b1;
            prio_rd     <= 1'b1;
            state       <= WR_RESP;
          end
        end
        RD_CAPT: begin
          s_rdata <= mem_rd_data;
          state   <= RD_RESP;
        end
        RD_RESP: if (s_rready) state <= IDLE;
        WR_RESP: if (s_bready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dma_reg_axil_ctrl.md
DMA_REG_AXIL_CTRL -- requirements
Module: dma_reg_axil_ctrl

Interface
REQ-001 SHALL have parameter ADDR_DECODER_WIDTH, default 8: low address bits used for register decode.
REQ-002 SHALL have parameter FRAME_SIZE_FIFO_ADDR, default 8'h28: decode offset whose read pops the frame-size FIFO.
REQ-003 SHALL have port aclk  in  1: single clock; all logic rising-edge.
REQ-004 SHALL have port aresetn  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have ports s_awaddr in 32 and s_araddr in 32: AXI4-Lite write and read addresses.
REQ-006 SHALL have ports s_awvalid in 1, s_awready out 1, s_wvalid in 1 and s_wready out 1: write address and data handshakes.
REQ-007 SHALL have ports s_wdata in 32 and s_wstrb in 4: write data and byte strobes.
REQ-008 SHALL have ports s_bvalid out 1, s_bready in 1 and s_bresp out 2: write response.
REQ-009 SHALL have ports s_arvalid in 1 and s_arready out 1: read address handshake.
REQ-010 SHALL have ports s_rvalid out 1, s_rready in 1, s_rdata out 32 and s_rresp out 2: read data channel.
REQ-011 SHALL have port mem_rd_addr  out  32: address to the combinational register-read mux.
REQ-012 SHALL have port mem_rd_data  in  32: data returned by the read mux, valid in the same cycle.
REQ-013 SHALL have ports mem_wr_en out 1, mem_wr_addr out 32, mem_wr_data out 32 and mem_wr_strb out 4: register write strobe and payload.
REQ-014 SHALL have port frame_size_fifo_ren  out  1: single-cycle pop pulse to the frame-size FIFO.

Function
REQ-015 SHALL implement the FSM states IDLE, RD_CAPT, RD_RESP and WR_RESP.
REQ-016 IDLE, read transaction:
  - a read SHALL be accepted (s_arready=1 for exactly 1 cycle) when s_arvalid=1 and read is selected per REQ-018.
  - s_araddr SHALL be registered onto mem_rd_addr.
  - the FSM SHALL go to RD_CAPT.
REQ-017 IDLE, write transaction:
  - a write SHALL be accepted only when s_awvalid=1 and s_wvalid=1 in the same cycle.
  - s_awready and s_wready SHALL both assert in that one cycle.
  - address, data and strobes SHALL be registered.
  - the FSM SHALL go to WR_RESP.
REQ-018 SHALL arbitrate simultaneous eligible read and write in IDLE round-robin:
  - a priority flag SHALL select the request that did not win last.
  - the flag SHALL reset to read-first.
  - a lone requester SHALL win regardless of the flag.
REQ-019 RD_CAPT (1 cycle):
  - mem_rd_data SHALL be captured into s_rdata.
  - frame_size_fifo_ren=1 SHALL be driven iff mem_rd_addr[ADDR_DECODER_WIDTH-1:0]==FRAME_SIZE_FIFO_ADDR.
  - the FSM SHALL go to RD_RESP.
REQ-020 RD_RESP:
  - s_rvalid=1 SHALL be driven, with s_rdata and s_rresp held stable until s_rready=1.
  - the FSM SHALL return to IDLE in the s_rready cycle.
REQ-021 Read latency: AR handshake at cycle T SHALL give s_rvalid=1 at T+2.
REQ-022 WR_RESP entry cycle (T+1 after acceptance): mem_wr_en SHALL be 1 for exactly that cycle, with mem_wr_addr/mem_wr_data/mem_wr_strb valid.
REQ-023 WR_RESP: s_bvalid SHALL be asserted from T+1 until s_bready=1, then the FSM SHALL return to IDLE.
REQ-024 s_rresp and s_bresp SHALL always be 2'b00 (OKAY); unmapped addresses SHALL return whatever mem_rd_data supplies.
REQ-025 Only one transaction SHALL be outstanding; no ready outputs SHALL assert outside IDLE.
REQ-026 frame_size_fifo_ren SHALL pulse at most once per accepted read, even if s_rready is held low for many cycles.
REQ-027 mem_rd_addr and mem_wr_* SHALL hold their last values between transactions.

Reset
REQ-028 aresetn=0 SHALL asynchronously force:
  - the FSM to IDLE;
  - all ready, valid, mem_wr_en and frame_size_fifo_ren outputs to 0;
  - s_rdata, mem_rd_addr, mem_wr_addr, mem_wr_data and mem_wr_strb to 0;
  - the priority flag to read-first.
REQ-029 Reset asserted mid-transaction SHALL abandon it: no response and no mem_wr_en after release.
REQ-030 The block SHALL accept a new transaction in the first cycle after aresetn deasserts.

Verification
REQ-031 SHALL cover read at 0x10 with mem_rd_data=0x00000001 -> s_rvalid at T+2, s_rdata=0x00000001, frame_size_fifo_ren stays 0.
REQ-032 SHALL cover read at 0x28 with s_rready low for 5 cycles -> exactly one frame_size_fifo_ren pulse at T+1, with s_rdata held for all 5 cycles.
REQ-033 SHALL cover write 0x04 <- 0xA5A5A5A5 with wstrb=4'hF -> mem_wr_en single pulse at T+1 with that addr/data, then s_bvalid until s_bready.
REQ-034 SHALL cover s_awvalid without s_wvalid for 3 cycles -> no s_awready until s_wvalid rises.
REQ-035 SHALL cover read and write requested simultaneously twice back-to-back -> read served first, write second, then read on the next conflict.
REQ-036 SHALL cover aresetn low during RD_RESP -> s_rvalid drops immediately; the next read completes normally.
